// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, legality check, flag indices and arbiter states
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_SLT  = 4'b0101,
    OP_SLL  = 4'b0110,
    OP_SRL  = 4'b0111,
    OP_XOR  = 4'b1000,
    OP_SLTU = 4'b1001
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic logic alu_op_legal(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT,
      OP_SLL, OP_SRL, OP_XOR, OP_SLTU: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// rtl/alu_rr_pick.sv - round-robin picker: first request at or after the pointer, wrapping
module alu_rr_pick #(
  parameter  int N_REQ = 2,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_sum   = '0;
    w_j     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // pointer is always < N_REQ, so one conditional subtract is enough to wrap
      w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(N_REQ)) w_sum = w_sum - (IDX_W+1)'(N_REQ);
      w_j = w_sum[IDX_W-1:0];
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_idx      = w_j;
        o_grant[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin share of one combinational ALU with a one-deep response register
// Optional requester lock for multi-word sequences: ALU_ARB_LOCK_EN.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter  int N_REQ  = 2,
  parameter  int DATA_W = 32,
  parameter  int OP_W   = 4,
  parameter  int TAG_W  = 4,
  localparam int IDX_W  = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    i_req_valid,
`ifdef ALU_ARB_LOCK_EN
  input  logic [N_REQ-1:0]    i_req_lock,
`endif
  output logic [N_REQ-1:0]    o_req_ready,
  input  logic [N_REQ*OP_W-1:0]   i_req_op,
  input  logic [N_REQ*DATA_W-1:0] i_req_a,
  input  logic [N_REQ*DATA_W-1:0] i_req_b,
  input  logic [N_REQ*TAG_W-1:0]  i_req_tag,
  output logic [OP_W-1:0]     o_alu_ctrl,
  output logic [DATA_W-1:0]   o_alu_a,
  output logic [DATA_W-1:0]   o_alu_b,
  input  logic [DATA_W-1:0]   i_alu_result,
  input  logic [3:0]          i_alu_flags,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [IDX_W-1:0]    o_rsp_id,
  output logic [TAG_W-1:0]    o_rsp_tag,
  output logic [DATA_W-1:0]   o_rsp_result,
  output logic [3:0]          o_rsp_flags,
  output logic                o_rsp_err
);

  logic [IDX_W-1:0]  r_rr_ptr;
  logic [OP_W-1:0]   r_alu_ctrl;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic              r_rsp_valid;
  logic [IDX_W-1:0]  r_rsp_id;
  logic [TAG_W-1:0]  r_rsp_tag;
  logic [DATA_W-1:0] r_rsp_result;
  logic [3:0]        r_rsp_flags;
  logic              r_rsp_err;

  logic [N_REQ-1:0]  w_pick_onehot;
  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_pick_any;
  logic [IDX_W-1:0]  w_holder;
  logic              w_locked;
  logic [IDX_W-1:0]  w_gidx;
  logic [IDX_W-1:0]  w_ptr_next;
  logic              w_slot_free;
  logic              w_grant;
  logic              w_legal;
  logic [OP_W-1:0]   w_op;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [TAG_W-1:0]  w_tag;

  alu_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req   (i_req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_onehot),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

`ifdef ALU_ARB_LOCK_EN
  arb_state_e       r_state;
  logic [IDX_W-1:0] r_holder;

  assign w_locked = (r_state == LOCKED);
  assign w_holder = r_holder;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ARB;
      r_holder <= '0;
    end else begin
      case (r_state)
        ARB: begin
          if (w_grant && i_req_lock[w_gidx]) begin
            r_state  <= LOCKED;
            r_holder <= w_gidx;
          end
        end
        LOCKED: begin
          // release on the holder's final (unlocked) transfer, or when it walks away idle
          if (!i_req_lock[r_holder] && (w_grant || !i_req_valid[r_holder])) r_state <= ARB;
        end
        default: r_state <= ARB;
      endcase
    end
  end
`else
  assign w_locked = 1'b0;
  assign w_holder = '0;
`endif

  assign w_slot_free = !r_rsp_valid || i_rsp_ready;
  assign w_gidx      = w_locked ? w_holder : w_pick_idx;
  assign w_grant     = rst_n && w_slot_free && (w_locked ? i_req_valid[w_holder] : w_pick_any);

  always_comb begin
    o_req_ready = '0;
    if (w_grant) begin
      if (w_locked) o_req_ready[w_holder] = 1'b1;
      else          o_req_ready = w_pick_onehot;
    end
  end

  assign w_op    = i_req_op [w_gidx*OP_W   +: OP_W];
  assign w_a     = i_req_a  [w_gidx*DATA_W +: DATA_W];
  assign w_b     = i_req_b  [w_gidx*DATA_W +: DATA_W];
  assign w_tag   = i_req_tag[w_gidx*TAG_W  +: TAG_W];
  assign w_legal = alu_op_legal(w_op);

  assign w_ptr_next = (w_gidx == IDX_W'(N_REQ-1)) ? '0 : w_gidx + IDX_W'(1);

  // ALU sees the granted operands in the grant cycle; otherwise it keeps the last op
  assign o_alu_ctrl = w_grant ? w_op : r_alu_ctrl;
  assign o_alu_a    = w_grant ? w_a  : r_alu_a;
  assign o_alu_b    = w_grant ? w_b  : r_alu_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr     <= '0;
      r_alu_ctrl   <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_tag    <= '0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
      r_rsp_err    <= 1'b0;
    end else if (w_grant) begin
      r_alu_ctrl   <= w_op;
      r_alu_a      <= w_a;
      r_alu_b      <= w_b;
      r_rsp_valid  <= 1'b1;
      r_rsp_id     <= w_gidx;
      r_rsp_tag    <= w_tag;
      r_rsp_result <= w_legal ? i_alu_result : '0;
      r_rsp_flags  <= w_legal ? i_alu_flags  : 4'b0000;
      r_rsp_err    <= !w_legal;
      if (!w_locked) r_rr_ptr <= w_ptr_next;
    end else if (i_rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_id     = r_rsp_id;
  assign o_rsp_tag    = r_rsp_tag;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_flags  = r_rsp_flags;
  assign o_rsp_err    = r_rsp_err;

endmodule
